reg_rename_file: RTL

//  Architectural register file plus per-register rename table (ROB tag of latest in-flight producer).

---
 rtl/reg_rename_file.sv | 115 +++++++++++
 1 files changed

// File: rtl/reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module  : reg_rename_file
// Purpose : Architectural register file with per-register rename tags (ROB
//           tag of the youngest in-flight producer), commit bypass on reads.
// Revision: 1.0 - initial release
// ============================================================================
module reg_rename_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             dispatch_rdy_in,
    input  logic [4:0]       dispatch_rd_in,
    input  logic [TAG_W-1:0] dispatch_tag_in,
    input  logic [4:0]       rs1_addr_in,
    input  logic [4:0]       rs2_addr_in,
    input  logic             commit_rdy_in,
    input  logic [4:0]       commit_rd_in,
    input  logic [XLEN-1:0]  commit_val_in,
    input  logic [TAG_W-1:0] commit_tag_in,
    output logic [XLEN-1:0]  rs1_val_out,
    output logic [TAG_W-1:0] rs1_rely_out,
    output logic [XLEN-1:0]  rs2_val_out,
    output logic [TAG_W-1:0] rs2_rely_out,
    output logic [5:0]       busy_cnt_out
);

    localparam int c_ADDR_W = 5;

    logic [XLEN-1:0]  w_val [0:NREG-1];
    logic [TAG_W-1:0] w_tag [0:NREG-1];
    logic [5:0]       w_busy_next;
    logic [5:0]       r_busy;

    // x0 has no storage: it always reads as a committed zero
    assign w_val[0] = '0;
    assign w_tag[0] = '0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            logic [XLEN-1:0]  r_val;
            logic [TAG_W-1:0] r_tag;
            logic             w_commit_hit;
            logic             w_dispatch_hit;

            assign w_commit_hit   = commit_rdy_in && (commit_rd_in == c_ADDR_W'(gi));
            assign w_dispatch_hit = dispatch_rdy_in && (dispatch_rd_in == c_ADDR_W'(gi));

            // Clear beats dispatch beats the commit tag release; the value
            // write from a commit is never suppressed.
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_val <= '0;
                    r_tag <= '0;
                end else if (rdy_in) begin
                    if (w_commit_hit)
                        r_val <= commit_val_in;
                    if (clear_in)
                        r_tag <= '0;
                    else if (w_dispatch_hit)
                        r_tag <= dispatch_tag_in;
                    else if (w_commit_hit && (r_tag == commit_tag_in))
                        r_tag <= '0;
                end
            end

            assign w_val[gi] = r_val;
            assign w_tag[gi] = r_tag;
        end
    endgenerate

    // A commit whose tag still owns the register resolves the read this cycle
    function automatic logic f_bypass(input logic [4:0] addr);
        return commit_rdy_in && (addr != '0) && (commit_rd_in == addr) &&
               (commit_tag_in == w_tag[addr]);
    endfunction

    always_comb begin
        rs1_val_out  = w_val[rs1_addr_in];
        rs1_rely_out = w_tag[rs1_addr_in];
        rs2_val_out  = w_val[rs2_addr_in];
        rs2_rely_out = w_tag[rs2_addr_in];
        if (f_bypass(rs1_addr_in)) begin
            rs1_val_out  = commit_val_in;
            rs1_rely_out = '0;
        end
        if (f_bypass(rs2_addr_in)) begin
            rs2_val_out  = commit_val_in;
            rs2_rely_out = '0;
        end
    end

    always_comb begin
        w_busy_next = '0;
        for (int i = 1; i < NREG; i++)
            w_busy_next = w_busy_next + 6'(w_tag[i] != '0);
    end

    // Count reflects the tag state as of the previous enabled cycle
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_busy <= '0;
        else if (rdy_in)
            r_busy <= w_busy_next;
    end

    assign busy_cnt_out = r_busy;

endmodule
`default_nettype wire
